mux16_1_wide_reg: RTL and testbench
===================================

MUX16_1_WIDE_REG -- requirements
Module: mux16_1_wide

Interface
REQ-001 Parameter: WIDTH, default 64, bit width of every data input and output.
REQ-002 Port clk, input, 1 bit, sole clock; all sequential elements are rising-edge triggered.
REQ-003 Port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 Port in, input, unpacked array [0:15] of WIDTH bits, the 16 candidate data words.
REQ-005 Port sel, input, 4 bits, index of the selected word.
REQ-006 Port out, output, WIDTH bits, combinational selection in[sel].
REQ-007 Port out_q, output, WIDTH bits, registered copy of out.

Function
REQ-008 Submodule mux2_1_wide SHALL exist with parameter WIDTH (default 64) and ports out[WIDTH-1:0], in[0:1] of WIDTH bits, and sel (1 bit).
REQ-009 mux2_1_wide SHALL drive out = in[0] when sel=0 and out = in[1] when sel=1, purely combinationally, with no clock or reset.
REQ-010 mux16_1_wide SHALL build out as a 4-level binary tree of 15 mux2_1_wide instances; no behavioural case or index shortcut.
REQ-011 Level 1 SHALL contain 8 instances pairing in[2k], in[2k+1] and selecting with sel[0].
REQ-012 Level 2 SHALL contain 4 instances selecting with sel[1].
REQ-013 Level 3 SHALL contain 2 instances selecting with sel[2].
REQ-014 Level 4 SHALL contain 1 instance selecting with sel[3], and its output SHALL drive out.
REQ-015 out SHALL equal in[sel] for every sel in 0..15 and every bit of every input, independently per bit lane.
REQ-016 out SHALL be combinational with zero clock latency and SHALL update whenever in or sel changes, regardless of clk or reset_n.
REQ-017 out_q SHALL load the value of out on every rising edge of clk while reset_n=1, giving one-cycle latency.
REQ-018 The register SHALL have no enable and no hold state.
REQ-019 All WIDTH bits SHALL pass unmodified, with no truncation, extension or inversion, for any WIDTH >= 1.
REQ-020 When sel changes in the same cycle as in, out_q SHALL capture in[sel] using the values sampled at that clock edge.
REQ-021 sel containing X or Z SHALL NOT be required to produce a defined out.

Reset
REQ-022 reset_n=0 SHALL force out_q to all zeros immediately, without waiting for a clk edge.
REQ-023 out_q SHALL remain all zeros while reset_n is held low.
REQ-024 Reset SHALL NOT affect out, which keeps tracking in[sel] during reset.
REQ-025 The first rising clk edge after reset_n rises SHALL load out_q with the current in[sel].
REQ-026 Reset asserted mid-operation SHALL discard the held out_q value; there is no other state.

Verification
REQ-027 Apply in[j]=j*0x0101010101010101 for j=0..15 and step sel through 0..15 -> out = in[sel] in the same cycle, and out_q equals it one clk later.
REQ-028 Apply in[5]=0xFFFFFFFFFFFFFFFF with all other inputs 0, sweep sel 0..15 -> out is all ones only at sel=5 and zero otherwise.
REQ-029 Standalone mux2_1_wide with in[0]=0xAAAA..AA and in[1]=0x5555..55 -> out=0xAAAA..AA at sel=0 and 0x5555..55 at sel=1.
REQ-030 Hold sel=15 with out_q=0xDEADBEEFCAFEF00D, then drive reset_n low between clk edges -> out_q=0 at once while out stays at in[15].
REQ-031 Run 256 iterations with all 16 inputs randomized and sel round-robin, checking each -> out == in[sel] and out_q == previous-cycle in[sel] every cycle.
REQ-032 Instantiate with WIDTH=1 and WIDTH=8 and run an exhaustive sel sweep -> correct selection and no width warnings.

Source files
------------

// File: rtl/mux16_1_wide_reg.sv
// 16:1 wide multiplexer built as a balanced tree of 2:1 muxes, with a
// registered copy of the selected word.
//
// mux2_1_wide      : purely combinational 2:1 word select.
// mux16_1_wide_reg : four levels of mux2_1_wide (sel[0] nearest the inputs,
//                    sel[3] at the root) driving out, plus a single
//                    always-loading register for out_q.

module mux2_1_wide #(
   parameter int WIDTH = 64
) (
   output logic [WIDTH-1:0] out,
   input  logic [WIDTH-1:0] in [0:1],
   input  logic             sel
);

   assign out = sel ? in[1] : in[0];

endmodule

module mux16_1_wide_reg #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] in [0:15],
   input  logic [3:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q
);

   logic [WIDTH-1:0] w_l1 [0:7];
   logic [WIDTH-1:0] w_l2 [0:3];
   logic [WIDTH-1:0] w_l3 [0:1];
   logic [WIDTH-1:0] r_out_q;

   // Level 1: adjacent input pairs, selected by sel[0]
   for (genvar k = 0; k < 8; k++) begin : g_lvl1
      logic [WIDTH-1:0] w_pair [0:1];
      assign w_pair[0] = in[2*k];
      assign w_pair[1] = in[2*k+1];
      mux2_1_wide #(.WIDTH(WIDTH)) u_mux (
         .out (w_l1[k]),
         .in  (w_pair),
         .sel (sel[0])
      );
   end

   // Level 2: selected by sel[1]
   for (genvar k = 0; k < 4; k++) begin : g_lvl2
      logic [WIDTH-1:0] w_pair [0:1];
      assign w_pair[0] = w_l1[2*k];
      assign w_pair[1] = w_l1[2*k+1];
      mux2_1_wide #(.WIDTH(WIDTH)) u_mux (
         .out (w_l2[k]),
         .in  (w_pair),
         .sel (sel[1])
      );
   end

   // Level 3: selected by sel[2]
   for (genvar k = 0; k < 2; k++) begin : g_lvl3
      logic [WIDTH-1:0] w_pair [0:1];
      assign w_pair[0] = w_l2[2*k];
      assign w_pair[1] = w_l2[2*k+1];
      mux2_1_wide #(.WIDTH(WIDTH)) u_mux (
         .out (w_l3[k]),
         .in  (w_pair),
         .sel (sel[2])
      );
   end

   // Level 4 (root): selected by sel[3], drives the combinational output
   logic [WIDTH-1:0] w_root [0:1];
   assign w_root[0] = w_l3[0];
   assign w_root[1] = w_l3[1];

   mux2_1_wide #(.WIDTH(WIDTH)) u_mux_root (
      .out (out),
      .in  (w_root),
      .sel (sel[3])
   );

   // Output register: loads every cycle, cleared asynchronously by reset
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_out_q <= '0;
      else          r_out_q <= out;
   end

   assign out_q = r_out_q;

endmodule

// File: tb/tb_mux16_1_wide_reg.sv
// Randomized self-checking bench for mux16_1_wide_reg (WIDTH 64, 8, 1) and a
// standalone mux2_1_wide. The reference is plain array indexing plus a
// one-entry "last captured word" for the register.

module tb_mux16_1_wide_reg;

   logic        clk;
   logic        reset_n;
   logic [3:0]  sel;
   logic [63:0] in64 [0:15];
   logic [7:0]  in8  [0:15];
   logic [0:0]  in1  [0:15];
   logic [63:0] out64, out_q64;
   logic [7:0]  out8,  out_q8;
   logic [0:0]  out1,  out_q1;

   logic [63:0] m2_in [0:1];
   logic        m2_sel;
   logic [63:0] m2_out;

   int n_checks = 0;
   int n_errors = 0;

   mux16_1_wide_reg #(.WIDTH(64)) u_dut64 (
      .clk (clk), .reset_n (reset_n), .in (in64), .sel (sel),
      .out (out64), .out_q (out_q64)
   );

   mux16_1_wide_reg #(.WIDTH(8)) u_dut8 (
      .clk (clk), .reset_n (reset_n), .in (in8), .sel (sel),
      .out (out8), .out_q (out_q8)
   );

   mux16_1_wide_reg #(.WIDTH(1)) u_dut1 (
      .clk (clk), .reset_n (reset_n), .in (in1), .sel (sel),
      .out (out1), .out_q (out_q1)
   );

   mux2_1_wide #(.WIDTH(64)) u_mux2 (
      .out (m2_out), .in (m2_in), .sel (m2_sel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Narrow instances see the low bits of the 64-bit words.
   task automatic copy_narrow();
      for (int j = 0; j < 16; j++) begin
         in8[j] = in64[j][7:0];
         in1[j] = in64[j][0:0];
      end
   endtask

   // Apply sel at the falling edge, check the combinational path, then check
   // the register one rising edge later against the word selected there.
   task automatic step(input string tag, input logic [3:0] s);
      logic [63:0] exp_word;
      @(negedge clk);
      sel = s;
      copy_narrow();
      #1;
      exp_word = in64[s];
      check({tag, "_out"},   out64,         exp_word);
      check({tag, "_out8"},  64'(out8),     64'(exp_word[7:0]));
      check({tag, "_out1"},  64'(out1),     64'(exp_word[0]));
      @(posedge clk);
      #1;
      check({tag, "_outq"},  out_q64,       exp_word);
      check({tag, "_outq8"}, 64'(out_q8),   64'(exp_word[7:0]));
      check({tag, "_outq1"}, 64'(out_q1),   64'(exp_word[0]));
   endtask

   task automatic randomize_inputs();
      for (int j = 0; j < 16; j++) in64[j] = {$urandom(), $urandom()};
   endtask

   initial begin
      logic [3:0] s;
      reset_n = 1'b0;
      sel     = 4'd3;
      m2_sel  = 1'b0;
      m2_in[0] = '0;
      m2_in[1] = '0;
      randomize_inputs();
      copy_narrow();

      // Reset state: register clear, combinational path alive
      #3;
      check("rst_outq",  out_q64, 64'd0);
      check("rst_out",   out64,   in64[3]);
      @(posedge clk); #1;
      check("rst_hold_outq", out_q64, 64'd0);
      check("rst_hold_out8", 64'(out_q8), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // First edge after reset loads the current selection
      step("first", 4'd3);

      // Graded pattern, sel swept 0..15
      for (int j = 0; j < 16; j++) in64[j] = 64'(j) * 64'h0101010101010101;
      for (int j = 0; j < 16; j++) step("pattern", 4'(j));

      // One-hot all-ones word at index 5
      for (int j = 0; j < 16; j++) in64[j] = '0;
      in64[5] = '1;
      for (int j = 0; j < 16; j++) step("onehot", 4'(j));

      // Standalone 2:1 mux
      m2_in[0] = 64'hAAAAAAAAAAAAAAAA;
      m2_in[1] = 64'h5555555555555555;
      m2_sel = 1'b0; #1;
      check("mux2_sel0", m2_out, 64'hAAAAAAAAAAAAAAAA);
      m2_sel = 1'b1; #1;
      check("mux2_sel1", m2_out, 64'h5555555555555555);

      // Asynchronous reset between edges
      randomize_inputs();
      in64[15] = 64'hDEADBEEFCAFEF00D;
      step("pre_rst", 4'd15);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_outq", out_q64, 64'd0);
      check("async_rst_out",  out64,   64'hDEADBEEFCAFEF00D);
      in64[15] = 64'h0123456789ABCDEF;
      #1;
      check("rst_track_out",  out64,   64'h0123456789ABCDEF);
      @(posedge clk); #1;
      check("rst_low_outq",   out_q64, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      step("post_rst", 4'd15);

      // Random data, round-robin select; inputs and sel change together
      for (int i = 0; i < 256; i++) begin
         randomize_inputs();
         s = 4'(i);
         step("rand", s);
      end

      // Random data with random select
      for (int i = 0; i < 64; i++) begin
         randomize_inputs();
         s = 4'($urandom_range(0, 15));
         step("rand_sel", s);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got=running expected=finished");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "simulation time limit exceeded");
   end

endmodule
